// File: rtl/clk_pkg.sv
// Shared types and helpers for the fabric clock-enable unit: FSM states,
// default timing constants and the per-channel divide-ratio field extractor.
package clk_pkg;

    typedef enum logic [1:0] {
        WAIT_LOCK = 2'd0,
        FILTER    = 2'd1,
        RELEASE   = 2'd2,
        RUN       = 2'd3
    } lock_state_e;

    localparam int DEFAULT_LOCK_FILTER = 64;
    localparam int DEFAULT_RST_STAGGER = 8;

    // Largest flat divide bus the extractor handles: 8 channels of up to 32 bits.
    localparam int MAX_CH    = 8;
    localparam int MAX_DIV_W = 32;
    localparam int FLAT_W    = MAX_CH * MAX_DIV_W;

    function automatic logic [MAX_DIV_W-1:0] div_field(
        input logic [FLAT_W-1:0] flat,
        input int                ch,
        input int                width
    );
        logic [FLAT_W-1:0]    shifted;
        logic [MAX_DIV_W-1:0] mask;
        shifted = flat >> (ch * width);
        mask    = (width >= MAX_DIV_W) ? '1
                                       : ((MAX_DIV_W'(1) << width) - MAX_DIV_W'(1));
        return shifted[MAX_DIV_W-1:0] & mask;
    endfunction

endpackage

// File: rtl/ce_divider.sv
// One clock-enable channel: programmable-ratio counter with a shadow ratio that
// is only adopted at a period boundary, so a reload never produces a runt strobe.
module ce_divider
    import clk_pkg::*;
#(
    parameter int DIV_W = 16
) (
    input  logic             i_clock,
    input  logic             i_reset,
    input  logic [DIV_W-1:0] i_div,
    input  logic             i_div_load,
    input  logic             i_hold,
    input  logic             i_hold_next,
    output logic             o_ce
);

    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic [DIV_W-1:0] shadow_q, shadow_d;
    logic [DIV_W-1:0] active_q, active_d;
    logic             ce_q, ce_d;
    logic             running;
    logic             term;

    // i_hold_next lets the strobe drop on the same edge the channel reset rises.
    always_comb begin
        shadow_d = shadow_q;
        cnt_d    = cnt_q;
        active_d = active_q;
        ce_d     = 1'b0;
        running  = !i_hold && !i_hold_next;
        term     = (cnt_q == (active_q - DIV_W'(1)));

        if (i_div_load) begin
            shadow_d = (i_div == '0) ? DIV_W'(1) : i_div;
        end

        if (!running) begin
            cnt_d = '0;
            if (i_hold) begin
                active_d = shadow_q;
            end
        end else if (term) begin
            cnt_d    = '0;
            ce_d     = 1'b1;
            active_d = shadow_q;
        end else begin
            cnt_d = cnt_q + DIV_W'(1);
        end
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            cnt_q    <= '0;
            shadow_q <= DIV_W'(1);
            active_q <= DIV_W'(1);
            ce_q     <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            shadow_q <= shadow_d;
            active_q <= active_d;
            ce_q     <= ce_d;
        end
    end

    assign o_ce = ce_q;

endmodule

// File: rtl/clock_enable_unit.sv
// Fabric clock-domain manager: qualifies PLL lock, releases channel resets in a
// staggered order and drives one programmable clock-enable strobe per channel.
module clock_enable_unit
    import clk_pkg::*;
#(
    parameter int N_CH        = 2,
    parameter int DIV_W       = 16,
    parameter int LOCK_FILTER = DEFAULT_LOCK_FILTER,
    parameter int RST_STAGGER = DEFAULT_RST_STAGGER
) (
    input  logic                  i_clock,
    input  logic                  i_reset,
    input  logic                  i_locked,
    input  logic [N_CH*DIV_W-1:0] i_div,
    input  logic                  i_div_load,
    output logic [N_CH-1:0]       o_ce,
    output logic [N_CH-1:0]       o_rst,
    output logic                  o_valid,
    output logic                  o_lock_lost
);

    localparam int FLT_W = $clog2(LOCK_FILTER);
    localparam int STG_W = (RST_STAGGER > 1) ? $clog2(RST_STAGGER) : 1;

    lock_state_e      state_q, state_d;
    logic             lk_meta_q, lk_meta_d;
    logic             lk_s_q, lk_s_d;
    logic [FLT_W-1:0] flt_cnt_q, flt_cnt_d;
    logic [STG_W-1:0] stg_cnt_q, stg_cnt_d;
    logic [N_CH-1:0]  rst_q, rst_d, rst_next_ch;
    logic             valid_q, valid_d;
    logic             lock_lost_q, lock_lost_d;

    // Clearing the lowest set bit of rst_q releases the channels in index order.
    always_comb begin
        lk_meta_d   = i_locked;
        lk_s_d      = lk_meta_q;
        state_d     = state_q;
        flt_cnt_d   = flt_cnt_q;
        stg_cnt_d   = stg_cnt_q;
        rst_d       = rst_q;
        lock_lost_d = lock_lost_q;
        rst_next_ch = rst_q & (rst_q - N_CH'(1));

        case (state_q)
            WAIT_LOCK: begin
                flt_cnt_d = '0;
                if (lk_s_q) begin
                    state_d = FILTER;
                end
            end
            FILTER: begin
                if (!lk_s_q) begin
                    state_d   = WAIT_LOCK;
                    flt_cnt_d = '0;
                end else if (flt_cnt_q == FLT_W'(LOCK_FILTER - 2)) begin
                    flt_cnt_d = '0;
                    stg_cnt_d = '0;
                    rst_d     = rst_next_ch;
                    state_d   = (rst_next_ch == '0) ? RUN : RELEASE;
                end else begin
                    flt_cnt_d = flt_cnt_q + FLT_W'(1);
                end
            end
            RELEASE, RUN: begin
                if (!lk_s_q) begin
                    state_d     = WAIT_LOCK;
                    stg_cnt_d   = '0;
                    rst_d       = '1;
                    lock_lost_d = 1'b1;
                end else if (state_q == RELEASE) begin
                    if (stg_cnt_q == STG_W'(RST_STAGGER - 1)) begin
                        stg_cnt_d = '0;
                        rst_d     = rst_next_ch;
                        if (rst_next_ch == '0) begin
                            state_d = RUN;
                        end
                    end else begin
                        stg_cnt_d = stg_cnt_q + STG_W'(1);
                    end
                end
            end
            default: state_d = WAIT_LOCK;
        endcase

        // Dividers look at rst_d, so they must also see the reset being applied.
        if (i_reset) begin
            rst_d = '1;
        end
        valid_d = |rst_d;
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            lk_meta_q   <= 1'b0;
            lk_s_q      <= 1'b0;
            state_q     <= WAIT_LOCK;
            flt_cnt_q   <= '0;
            stg_cnt_q   <= '0;
            rst_q       <= '1;
            valid_q     <= 1'b1;
            lock_lost_q <= 1'b0;
        end else begin
            lk_meta_q   <= lk_meta_d;
            lk_s_q      <= lk_s_d;
            state_q     <= state_d;
            flt_cnt_q   <= flt_cnt_d;
            stg_cnt_q   <= stg_cnt_d;
            rst_q       <= rst_d;
            valid_q     <= valid_d;
            lock_lost_q <= lock_lost_d;
        end
    end

    for (genvar k = 0; k < N_CH; k++) begin : g_ch
        logic [DIV_W-1:0] ch_div;
        assign ch_div = DIV_W'(div_field(FLAT_W'(i_div), k, DIV_W));

        ce_divider #(
            .DIV_W(DIV_W)
        ) u_div (
            .i_clock    (i_clock),
            .i_reset    (i_reset),
            .i_div      (ch_div),
            .i_div_load (i_div_load),
            .i_hold     (rst_q[k]),
            .i_hold_next(rst_d[k]),
            .o_ce       (o_ce[k])
        );
    end

    assign o_rst       = rst_q;
    assign o_valid     = valid_q;
    assign o_lock_lost = lock_lost_q;

endmodule

// File: tb/tb_clock_enable_unit.sv
// Directed bench for clock_enable_unit: lock qualification, staggered release,
// divider rates and reloads, lock loss and reset behaviour against hand-timed values.
module tb_clock_enable_unit;

    localparam int N_CH  = 2;
    localparam int DIV_W = 16;

    logic                  clock = 1'b0;
    logic                  reset;
    logic                  locked;
    logic [N_CH*DIV_W-1:0] div;
    logic                  divLoad;
    logic [N_CH-1:0]       ce;
    logic [N_CH-1:0]       rst;
    logic                  valid;
    logic                  lockLost;

    int cyc;
    int checkCount;
    int errorCount;

    always #5 clock = ~clock;

    clock_enable_unit #(
        .N_CH       (N_CH),
        .DIV_W      (DIV_W),
        .LOCK_FILTER(64),
        .RST_STAGGER(8)
    ) dut (
        .i_clock    (clock),
        .i_reset    (reset),
        .i_locked   (locked),
        .i_div      (div),
        .i_div_load (divLoad),
        .o_ce       (ce),
        .o_rst      (rst),
        .o_valid    (valid),
        .o_lock_lost(lockLost)
    );

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc, actual, expected);
        end
    endtask

    task automatic checkAll(input string tag, input logic [1:0] expRst, input logic [1:0] expCe,
                            input logic expValid, input logic expLost);
        checkOutput({tag, "_rst"},   32'(rst),      32'(expRst));
        checkOutput({tag, "_ce"},    32'(ce),       32'(expCe));
        checkOutput({tag, "_valid"}, 32'(valid),    32'(expValid));
        checkOutput({tag, "_lost"},  32'(lockLost), 32'(expLost));
    endtask

    task automatic applyStimulus(input logic rstIn, input logic lockIn, input logic [15:0] div1,
                                 input logic [15:0] div0, input logic load);
        reset   = rstIn;
        locked  = lockIn;
        div     = {div1, div0};
        divLoad = load;
    endtask

    task automatic step();
        @(posedge clock);
        cyc++;
        #1;
    endtask

    task automatic goTo(input int n);
        while (cyc < n) step();
    endtask

    initial begin
        checkCount = 0;
        errorCount = 0;
        cyc        = 0;
        applyStimulus(1'b1, 1'b0, 16'd0, 16'd0, 1'b0);
        step(); step(); step();
        checkAll("reset", 2'b11, 2'b00, 1'b1, 1'b0);

        // Power-up: lock from cycle 0, load div0=1, div1=5 while channels are held.
        applyStimulus(1'b0, 1'b1, 16'd5, 16'd1, 1'b1);
        cyc = 0;
        step();
        applyStimulus(1'b0, 1'b1, 16'd5, 16'd1, 1'b0);
        goTo(65);  checkOutput("preRelease_rst", 32'(rst), 32'h3);
        goTo(66);  checkAll("rst0Release", 2'b10, 2'b00, 1'b1, 1'b0);
        goTo(67);  checkOutput("ce0First", 32'(ce), 32'h1);
        goTo(73);  checkOutput("rst1Held", 32'(rst), 32'h2);
        goTo(74);  checkAll("rst1Release", 2'b00, 2'b01, 1'b0, 1'b0);
        goTo(78);  checkOutput("ce1BeforeFirst", 32'(ce), 32'h1);
        goTo(79);  checkOutput("ce1First", 32'(ce), 32'h3);
        goTo(80);  checkOutput("ce1Width", 32'(ce), 32'h1);
        goTo(84);  checkOutput("ce1Period5", 32'(ce), 32'h3);

        // Reload div1=3 mid-period: the running 5-cycle period must complete.
        goTo(86);
        applyStimulus(1'b0, 1'b1, 16'd3, 16'd1, 1'b1);
        step();
        applyStimulus(1'b0, 1'b1, 16'd3, 16'd1, 1'b0);
        goTo(88);  checkOutput("reloadOld88", 32'(ce), 32'h1);
        goTo(89);  checkOutput("reloadOldEnd", 32'(ce), 32'h3);
        goTo(90);  checkOutput("reloadNo90", 32'(ce), 32'h1);
        goTo(91);  checkOutput("reloadNo91", 32'(ce), 32'h1);
        goTo(92);  checkOutput("reloadNew92", 32'(ce), 32'h3);
        goTo(95);  checkOutput("reloadNew95", 32'(ce), 32'h3);

        // Reload div1=5 on the terminal-count cycle: one more period of 3 first.
        goTo(97);
        applyStimulus(1'b0, 1'b1, 16'd5, 16'd1, 1'b1);
        step();
        applyStimulus(1'b0, 1'b1, 16'd5, 16'd1, 1'b0);
        checkOutput("tcLoad98", 32'(ce), 32'h3);
        goTo(101); checkOutput("tcLoad101", 32'(ce), 32'h3);
        goTo(104); checkOutput("tcLoad104", 32'(ce), 32'h1);
        goTo(105); checkOutput("tcLoad105", 32'(ce), 32'h1);
        goTo(106); checkOutput("tcLoad106", 32'(ce), 32'h3);

        // Lock loss in RUN, then re-lock with the sticky flag held.
        goTo(110);
        applyStimulus(1'b0, 1'b0, 16'd5, 16'd1, 1'b0);
        goTo(112); checkAll("preLoss", 2'b00, 2'b01, 1'b0, 1'b0);
        goTo(113); checkAll("lockLoss", 2'b11, 2'b00, 1'b1, 1'b1);
        goTo(120);
        applyStimulus(1'b0, 1'b1, 16'd5, 16'd1, 1'b0);
        goTo(185); checkOutput("relockHeld", 32'(rst), 32'h3);
        goTo(186); checkAll("relockRst0", 2'b10, 2'b00, 1'b1, 1'b1);
        goTo(194); checkAll("relockRun", 2'b00, 2'b01, 1'b0, 1'b1);

        // Fresh reset, div0=0, and a one-cycle lock glitch at filter count 30.
        applyStimulus(1'b1, 1'b0, 16'd0, 16'd0, 1'b0);
        step(); step();
        checkAll("reset2", 2'b11, 2'b00, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b1, 16'd1, 16'd0, 1'b1);
        cyc = 0;
        step();
        applyStimulus(1'b0, 1'b1, 16'd1, 16'd0, 1'b0);
        goTo(31);
        applyStimulus(1'b0, 1'b0, 16'd1, 16'd0, 1'b0);
        step();
        applyStimulus(1'b0, 1'b1, 16'd1, 16'd0, 1'b0);
        goTo(66);  checkOutput("glitchNoEarly", 32'(rst), 32'h3);
        goTo(97);  checkOutput("glitchHeld97", 32'(rst), 32'h3);
        goTo(98);  checkAll("glitchRelease", 2'b10, 2'b00, 1'b1, 1'b0);
        goTo(99);  checkOutput("div0Zero99", 32'(ce), 32'h1);
        goTo(100); checkOutput("div0Zero100", 32'(ce), 32'h1);

        // Reset mid-RELEASE, with a load pulse during reset that must be ignored.
        applyStimulus(1'b1, 1'b1, 16'd4, 16'd4, 1'b1);
        step();
        checkAll("midReleaseReset", 2'b11, 2'b00, 1'b1, 1'b0);
        applyStimulus(1'b1, 1'b1, 16'd4, 16'd4, 1'b0);
        step(); step();
        applyStimulus(1'b0, 1'b1, 16'd4, 16'd4, 1'b0);
        cyc = 0;
        goTo(66);  checkOutput("afterReset_rst", 32'(rst), 32'h2);
        goTo(67);  checkOutput("loadIgnored67", 32'(ce), 32'h1);
        goTo(68);  checkOutput("loadIgnored68", 32'(ce), 32'h1);

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
